// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter for a shared FIFO write port. One producer at a
//   time holds a grant for up to MAX_BURST words. Its data is muxed onto the
//   FIFO write port. An exact occupancy count gates writes, because the
//   FIFO's own registered flags lag by one cycle.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-producer word valid
//   req_data      producer i data at [i*DW +: DW]
//   req_ready     per-producer accept (combinational)
//   fifo_wr_en    FIFO write strobe (combinational)
//   fifo_data_in  FIFO write data (combinational mux of granted producer)
//   fifo_rd_en    consumer read strobe (observed only)
//   occupancy     registered word count, 0..DEPTH
//   grant_id      registered current/last owner
//   busy          high while a grant is held
//   almost_full   registered, occupancy >= AF_LEVEL
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 8,
  parameter int AF_LEVEL  = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      fifo_wr_en,
  output logic [DW-1:0]             fifo_data_in,
  input  logic                      fifo_rd_en,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      almost_full
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] grant_nxt, pick, rr_idx;
  logic          pick_vld;
  logic [BW-1:0] burst_cnt, burst_cnt_nxt;
  logic [OW-1:0] occ_nxt;
  logic          space, xfer, rd;

  // A read in the same cycle does not free space for a write.
  assign space = (occupancy < OW'(DEPTH));
  // Reads of an empty FIFO are ignored.
  assign rd    = fifo_rd_en & (occupancy != '0);
  assign busy  = (state == BURST);
  assign fifo_data_in = req_data[grant_id*DW +: DW];
  assign occ_nxt = occupancy + OW'(xfer) - OW'(rd);

  // First valid requester after last_grant, wrapping; last_grant itself is
  // visited last so the previous owner has lowest priority.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = GW'((32'(last_grant) + k) % NREQ);
      if (!pick_vld && req_valid[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    req_ready      = '0;
    xfer           = 1'b0;
    fifo_wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        req_ready[grant_id] = space;
        xfer       = req_valid[grant_id] & space;
        fifo_wr_en = xfer;
        if (xfer)
          burst_cnt_nxt = burst_cnt + 1'b1;
        // Full FIFO with valid high holds the grant without counting.
        if (!req_valid[grant_id] ||
            (xfer && burst_cnt == BW'(MAX_BURST - 1))) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      last_grant  <= GW'(NREQ - 1);
      burst_cnt   <= '0;
      occupancy   <= '0;
      almost_full <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      last_grant  <= last_grant_nxt;
      burst_cnt   <= burst_cnt_nxt;
      occupancy   <= occ_nxt;
      almost_full <= (occ_nxt >= OW'(AF_LEVEL));
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter: directed vector table,
//   hand-written multi-cycle sequences, and randomized traffic compared
//   against a behavioural model of the arbitration and occupancy rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 32;
  localparam int DEPTH     = 32;
  localparam int MAX_BURST = 8;
  localparam int AF_LEVEL  = 28;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_data_in;
  logic                 fifo_rd_en;
  logic [5:0]           occupancy;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 almost_full;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_rd_en(fifo_rd_en), .occupancy(occupancy), .grant_id(grant_id),
    .busy(busy), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Leaves time at posedge+1; inputs change there, outputs checked at +2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_rd_en = 1'b0; rand_data();
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr", 32'(fifo_wr_en), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_data", fifo_data_in, req_data[DW-1:0]);
  endtask

  typedef struct {
    logic [3:0] v;
    logic       rd;
    logic [7:0] d0;
    logic       ew;
    logic [3:0] er;
    int         eocc;
    int         egid;
    logic       eb;
  } vec_t;

  vec_t tbl[12];

  // Behavioural model state
  int m_owner, m_last, m_gid, m_words, m_occ;

  initial begin
    bit found;
    int order[$];
    int wcnt[$];
    logic prev_busy;
    int rdp;

    // ---------------- table: single producer burst of 8 ----------------
    tbl[0] = '{4'b0001, 1'b0, 8'hA0, 1'b0, 4'b0000, 0, 0, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{4'b0001, 1'b0, 8'(8'hA0 + i - 1), 1'b1, 4'b0001, i - 1, 0, 1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 8'hFF, 1'b0, 4'b0000, 8, 0, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 8'hFF, 1'b0, 4'b0000, 8, 0, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 8'hFF, 1'b0, 4'b0000, 7, 0, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].v;
      fifo_rd_en = tbl[i].rd;
      rand_data();
      req_data[DW-1:0] = 32'(tbl[i].d0);
      #1;
      chk("tbl_wr", 32'(fifo_wr_en), 32'(tbl[i].ew));
      chk("tbl_ready", 32'(req_ready), 32'(tbl[i].er));
      chk("tbl_occ", 32'(occupancy), tbl[i].eocc);
      chk("tbl_gid", 32'(grant_id), tbl[i].egid);
      chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
      if (tbl[i].ew) chk("tbl_data", fifo_data_in, 32'(tbl[i].d0));
      step();
    end

    // ---------------- rotation, fill to full, stall, read-one ----------------
    do_reset();
    req_valid = 4'b1111;
    prev_busy = 1'b0;
    for (int c = 0; c < 37; c++) begin
      rand_data();
      #1;
      if (busy && !prev_busy) begin
        order.push_back(int'(grant_id));
        wcnt.push_back(0);
      end
      if (fifo_wr_en && wcnt.size() > 0) wcnt[wcnt.size()-1] = wcnt[wcnt.size()-1] + 1;
      if (occupancy == 6'd27) chk("af_at27", 32'(almost_full), 0);
      if (occupancy == 6'd28) chk("af_at28", 32'(almost_full), 1);
      prev_busy = busy;
      step();
    end
    chk("rot_nbursts", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      chk("rot_order", order[k], k);
      chk("rot_words", wcnt[k], MAX_BURST);
    end
    step(); step();
    #1;
    chk("full_busy", 32'(busy), 1);
    chk("full_gid", 32'(grant_id), 0);
    chk("full_occ", 32'(occupancy), DEPTH);
    chk("full_ready", 32'(req_ready), 0);
    chk("full_wr", 32'(fifo_wr_en), 0);
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    #1;
    chk("rd1_occ", 32'(occupancy), DEPTH - 1);
    chk("rd1_ready", 32'(req_ready), 32'h1);
    chk("rd1_wr", 32'(fifo_wr_en), 1);
    step();
    #1;
    chk("refill_occ", 32'(occupancy), DEPTH);
    chk("refill_wr", 32'(fifo_wr_en), 0);

    // ---------------- simultaneous read/write, read when empty ----------------
    do_reset();
    req_valid = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (occupancy == 6'd10 && fifo_wr_en) found = 1'b1;
      else step();
    end
    chk("rw_reach10", 32'(found), 1);
    fifo_rd_en = 1'b1;
    step();
    #1;
    chk("rw_occ", 32'(occupancy), 10);
    req_valid = '0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      #1;
      if (occupancy == 6'd0) found = 1'b1;
      else step();
    end
    chk("drain_reach0", 32'(found), 1);
    step();
    #1;
    chk("empty_rd_occ", 32'(occupancy), 0);
    step();
    #1;
    chk("empty_rd_occ2", 32'(occupancy), 0);
    fifo_rd_en = 1'b0;

    // ---------------- reset mid-burst ----------------
    do_reset();
    req_valid = 4'b0001;
    step(); step(); step();
    req_valid = 4'b0100;
    step(); step(); step(); step(); step();
    #1;
    chk("mid_gid", 32'(grant_id), 2);
    chk("mid_occ", 32'(occupancy), 5);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_occ", 32'(occupancy), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    req_valid = 4'b1111;
    step();
    #1;
    chk("mrst_next_gid", 32'(grant_id), 0);
    chk("mrst_next_busy", 32'(busy), 1);

    // ---------------- randomized traffic vs. model ----------------
    do_reset();
    m_owner = -1; m_last = NREQ - 1; m_gid = 0; m_words = 0; m_occ = 0;
    rdp = 30;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] exp_ready;
      bit exp_wr, m_rd;
      if (c % 500 == 0) rdp = $urandom_range(5, 70);
      for (int i = 0; i < NREQ; i++) req_valid[i] = ($urandom_range(0, 99) < 80);
      fifo_rd_en = ($urandom_range(0, 99) < rdp);
      rand_data();
      #1;
      exp_ready = '0;
      exp_wr = 1'b0;
      if (m_owner >= 0 && m_occ < DEPTH) begin
        exp_ready[m_owner] = 1'b1;
        exp_wr = req_valid[m_owner];
      end
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_wr", 32'(fifo_wr_en), 32'(exp_wr));
      if (exp_wr) chk("rnd_data", fifo_data_in, req_data[m_owner*DW +: DW]);
      chk("rnd_occ", 32'(occupancy), m_occ);
      chk("rnd_gid", 32'(grant_id), m_gid);
      chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
      chk("rnd_af", 32'(almost_full), 32'(m_occ >= AF_LEVEL));
      // advance the model by one cycle
      m_rd = fifo_rd_en && (m_occ > 0);
      m_occ = m_occ + int'(exp_wr) - int'(m_rd);
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_owner < 0 && req_valid[(m_last + k) % NREQ]) begin
            m_owner = (m_last + k) % NREQ;
            m_gid = m_owner;
            m_words = 0;
          end
        end
      end else if (!req_valid[m_owner]) begin
        m_last = m_owner;
        m_owner = -1;
      end else if (exp_wr) begin
        m_words++;
        if (m_words == MAX_BURST) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter and occupancy controller that shares one 32x32 FIFO write port among NREQ producers.
- Grants one producer at a time for a bounded burst, muxes its data onto the FIFO write port, and keeps an exact occupancy count.
- Gates writes with its own count, because the FIFO's registered full/empty flags lag by one cycle.
- The FIFO consumer reads via fifo_rd_en, which this block observes.

Parameters:
- NREQ, 4, number of producers (2..8)
- DW, 32, data width
- DEPTH, 32, FIFO entries
- MAX_BURST, 8, max words per grant before forced rotation (1..DEPTH)
- AF_LEVEL, 28, almost_full asserted when occupancy >= AF_LEVEL

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-producer word valid
- req_data  input  NREQ*DW  producer i data at bits [i*DW +: DW]
- req_ready  output  NREQ  per-producer accept (combinational)
- fifo_wr_en  output  1  FIFO write strobe (combinational)
- fifo_data_in  output  DW  FIFO write data (combinational mux)
- fifo_rd_en  input  1  consumer read strobe, observed
- occupancy  output  $clog2(DEPTH)+1  registered word count, 0..DEPTH
- grant_id  output  $clog2(NREQ)  registered current/last owner
- busy  output  1  high in state BURST
- almost_full  output  1  registered, occupancy >= AF_LEVEL

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - state=IDLE, grant_id=0, last_grant=NREQ-1, burst_cnt=0, occupancy=0, almost_full=0.
  - req_ready=0, fifo_wr_en=0, busy=0, fifo_data_in=req_data[0 slice].
  - Reset mid-burst aborts the grant. Occupancy clears to 0; the FIFO shares rst, so it clears too.
- space = (occupancy < DEPTH). A read in the same cycle does NOT free space for a write.
- State IDLE:
  - If any req_valid, pick the first valid index searching last_grant+1, +2, ... (mod NREQ).
  - Registered: grant_id <= pick, burst_cnt <= 0, state <= BURST.
  - Arbitration costs exactly 1 cycle; no transfer occurs in IDLE.
- State BURST, g = grant_id:
  - req_ready[g] = space; all other ready bits = 0.
  - xfer = req_valid[g] & req_ready[g]. fifo_wr_en = xfer; fifo_data_in = req_data[g].
  - On xfer: burst_cnt += 1.
  - Release, i.e. state <= IDLE and last_grant <= g, when either:
    - req_valid[g] == 0 (no transfer that cycle), or
    - xfer with burst_cnt == MAX_BURST-1 (the last word is written that cycle).
  - space == 0 with valid high: hold the grant and stall. Stall cycles do not count toward the burst.
- Occupancy, next cycle:
  - rd = fifo_rd_en & (occupancy != 0). Reads while occupancy == 0 are ignored, not counted.
  - occupancy += xfer - rd. Simultaneous write and read leaves it unchanged.
  - Never exceeds DEPTH, never goes below 0.
- almost_full and busy derive from registered state; no combinational path from fifo_rd_en to any output.
- Fairness: after a release, the released requester has lowest priority. Worst-case wait = (NREQ-1)*(MAX_BURST+1) cycles with the FIFO not full.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[0]=0xA0..0xA7 for 8 words -> grant_id=0 the cycle after valid; 8 fifo_wr_en pulses with matching data; release to IDLE; occupancy=8.
- req_valid=4'b1111 held continuously, MAX_BURST=8 -> grants rotate 0,1,2,3,0. Each burst is exactly 8 writes, followed by one IDLE gap cycle.
- Fill to occupancy=32 with no reads -> req_ready=0 and fifo_wr_en=0 while the grant is held. One fifo_rd_en pulse -> occupancy=31, then the next cycle one write is accepted -> 32.
- At occupancy=10, a write and fifo_rd_en in the same cycle -> occupancy stays 10. fifo_rd_en at occupancy=0 -> stays 0.
- occupancy crosses 27->28 -> almost_full=1 on the following cycle; it drops at 27.
- Assert rst mid-burst (grant_id=2, burst_cnt=3, occupancy=5) -> next cycle state=IDLE, occupancy=0, req_ready=0. The following grant search starts at index 0.
